// File: rtl/ac97_pkg.sv
// AC'97 link constants shared by the transmit and receive paths: frame geometry,
// tag bit positions, codec register indices and the command entry layout.
package ac97_pkg;

  localparam int FRAME_BITS = 256;
  localparam int SLOT_BITS  = 20;
  localparam int TAG_BITS   = 16;

  localparam int TAG_VALID     = 15;
  localparam int TAG_CMD_ADDR  = 14;
  localparam int TAG_CMD_DATA  = 13;
  localparam int TAG_PCM_LEFT  = 12;
  localparam int TAG_PCM_RIGHT = 11;

  localparam logic [6:0] REG_MASTER_VOL = 7'h02;
  localparam logic [6:0] REG_MIC_VOL    = 7'h0E;
  localparam logic [6:0] REG_REC_SEL    = 7'h1A;
  localparam logic [6:0] REG_REC_GAIN   = 7'h1C;

  typedef struct packed {
    logic        read;
    logic [6:0]  addr;
    logic [15:0] data;
  } cmd_t;

  // First frame bit (counted from the MSB end) of slot n; slot 0 is the 16-bit tag.
  function automatic int slot_start(input int n);
    return (n == 0) ? 0 : TAG_BITS + SLOT_BITS * (n - 1);
  endfunction

endpackage

// File: rtl/ac97_bit_timer.sv
// Frame bit timer: free-running 256-bit position counter driving registered SYNC and
// frame-start outputs, plus the combinational strobe for loading the next frame.
module ac97_bit_timer
  import ac97_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic sync,
  output logic frame_start,
  output logic latch
);

  localparam logic [7:0] SYNC_END = 8'(TAG_BITS);

  // count is the index of the bit that appears on the outputs after the next edge.
  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= 8'd0;
      sync        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      count       <= count + 8'd1;
      sync        <= (count < SYNC_END);
      frame_start <= (count == 8'd0);
    end
  end

  assign latch = (count == 8'd0);

endmodule

// File: rtl/ac97_frame_tx.sv
// AC'97 controller transmitter: holds one command and one stereo sample, packs them into
// a 256-bit frame at each frame boundary and shifts it out MSB first alongside SYNC.
module ac97_frame_tx
  import ac97_pkg::*;
#(
  parameter int SAMPLE_W = 18
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                CmdValid,
  output logic                CmdReady,
  input  logic                CmdRead,
  input  logic [6:0]          CmdAddr,
  input  logic [15:0]         CmdData,
  input  logic                PcmValid,
  output logic                PcmReady,
  input  logic [SAMPLE_W-1:0] PcmLeft,
  input  logic [SAMPLE_W-1:0] PcmRight,
  output logic                Sync,
  output logic                SData,
  output logic                FrameStart
);

  localparam int TAG_MSB   = FRAME_BITS - 1;
  localparam int SLOT1_MSB = FRAME_BITS - 1 - slot_start(1);
  localparam int SLOT2_MSB = FRAME_BITS - 1 - slot_start(2);
  localparam int SLOT3_MSB = FRAME_BITS - 1 - slot_start(3);
  localparam int SLOT4_MSB = FRAME_BITS - 1 - slot_start(4);

  logic                  latch;
  logic                  cmd_held;
  logic                  pcm_held;
  cmd_t                  cmd_q;
  logic [SAMPLE_W-1:0]   left_q;
  logic [SAMPLE_W-1:0]   right_q;
  logic [TAG_BITS-1:0]   tag;
  logic [FRAME_BITS-1:0] frame;
  logic [FRAME_BITS-2:0] shift_q;

  function automatic logic [SLOT_BITS-1:0] align(input logic [SAMPLE_W-1:0] sample);
    align = '0;
    align[SLOT_BITS-1 -: SAMPLE_W] = sample;
  endfunction

  ac97_bit_timer u_timer (
    .clk         (Clock),
    .reset       (Reset),
    .sync        (Sync),
    .frame_start (FrameStart),
    .latch       (latch)
  );

  assign CmdReady = ~cmd_held;
  assign PcmReady = ~pcm_held;

  // An entry accepted in the latch cycle survives the latch and waits for the next frame.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cmd_held <= 1'b0;
      cmd_q    <= '0;
    end else if (CmdValid && CmdReady) begin
      cmd_held <= 1'b1;
      cmd_q    <= '{read: CmdRead, addr: CmdAddr, data: CmdData};
    end else if (latch) begin
      cmd_held <= 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pcm_held <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
    end else if (PcmValid && PcmReady) begin
      pcm_held <= 1'b1;
      left_q   <= PcmLeft;
      right_q  <= PcmRight;
    end else if (latch) begin
      pcm_held <= 1'b0;
    end
  end

  always_comb begin
    tag = '0;
    tag[TAG_VALID]     = cmd_held | pcm_held;
    tag[TAG_CMD_ADDR]  = cmd_held;
    tag[TAG_CMD_DATA]  = cmd_held & ~cmd_q.read;
    tag[TAG_PCM_LEFT]  = pcm_held;
    tag[TAG_PCM_RIGHT] = pcm_held;

    frame = '0;
    frame[TAG_MSB -: TAG_BITS] = tag;
    if (cmd_held) begin
      frame[SLOT1_MSB -: SLOT_BITS] = {cmd_q.read, cmd_q.addr, 12'b0};
    end
    if (cmd_held && !cmd_q.read) begin
      frame[SLOT2_MSB -: SLOT_BITS] = {cmd_q.data, 4'b0};
    end
    if (pcm_held) begin
      frame[SLOT3_MSB -: SLOT_BITS] = align(left_q);
      frame[SLOT4_MSB -: SLOT_BITS] = align(right_q);
    end
  end

  // Bit 0 goes straight to SData at the latch; the remaining 255 bits wait in the shifter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      SData   <= 1'b0;
      shift_q <= '0;
    end else if (latch) begin
      SData   <= frame[FRAME_BITS-1];
      shift_q <= frame[FRAME_BITS-2:0];
    end else begin
      SData   <= shift_q[FRAME_BITS-2];
      shift_q <= {shift_q[FRAME_BITS-3:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Self-checking bench for ac97_frame_tx: a frame-level reference model checked every cycle,
// plus directed frames whose fields are compared against hand-computed constants.
module tb_ac97_frame_tx;

  localparam int SW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [6:0]    cmd_addr;
  logic [15:0]   cmd_data;
  logic          pcm_valid;
  logic          pcm_ready;
  logic [SW-1:0] pcm_left;
  logic [SW-1:0] pcm_right;
  logic          sync;
  logic          sdata;
  logic          frame_start;

  always #5 clk = ~clk;

  ac97_frame_tx #(.SAMPLE_W(SW)) dut (
    .Clock      (clk),
    .Reset      (rst),
    .CmdValid   (cmd_valid),
    .CmdReady   (cmd_ready),
    .CmdRead    (cmd_read),
    .CmdAddr    (cmd_addr),
    .CmdData    (cmd_data),
    .PcmValid   (pcm_valid),
    .PcmReady   (pcm_ready),
    .PcmLeft    (pcm_left),
    .PcmRight   (pcm_right),
    .Sync       (sync),
    .SData      (sdata),
    .FrameStart (frame_start)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame assembled directly from the slot rules as tag + four slots + padding.
  function automatic logic [255:0] build_frame(input bit ch, input bit rd, input logic [6:0] a,
                                               input logic [15:0] d, input bit ph,
                                               input logic [SW-1:0] l, input logic [SW-1:0] r);
    logic [15:0] t;
    logic [19:0] s1, s2, s3, s4;
    t = 16'h0; s1 = 20'h0; s2 = 20'h0; s3 = 20'h0; s4 = 20'h0;
    if (ch || ph) t = t + 16'h8000;
    if (ch) t = t + 16'h4000;
    if (ch && !rd) t = t + 16'h2000;
    if (ph) t = t + 16'h1800;
    if (ch) s1 = 20'({rd, a}) * 20'd4096;
    if (ch && !rd) s2 = 20'(d) * 20'd16;
    if (ph) begin
      s3 = 20'(l) << (20 - SW);
      s4 = 20'(r) << (20 - SW);
    end
    return {t, s1, s2, s3, s4, 160'h0};
  endfunction

  function automatic logic [31:0] tag_of(input logic [255:0] f);
    return 32'(f[255:240]);
  endfunction

  function automatic logic [31:0] slot_of(input logic [255:0] f, input int n);
    return 32'(f[239 - 20 * (n - 1) -: 20]);
  endfunction

  // Model state: m_pos is the frame bit on the outputs this cycle, -1 while held in reset.
  bit            m_ok = 1'b0;
  int            m_pos = -1;
  bit            m_ch = 1'b0, m_ph = 1'b0, m_rd = 1'b0;
  logic [6:0]    m_a = '0;
  logic [15:0]   m_d = '0;
  logic [SW-1:0] m_l = '0, m_r = '0;
  logic [255:0]  m_frame = '0;

  always @(posedge clk) begin
    bit acc_c, acc_p;
    int np;
    if (rst) begin
      m_ok = 1'b1; m_pos = -1; m_ch = 1'b0; m_ph = 1'b0; m_frame = '0;
    end else if (m_ok) begin
      acc_c = cmd_valid && !m_ch;
      acc_p = pcm_valid && !m_ph;
      np = (m_pos + 1) % 256;
      if (np == 0) begin
        m_frame = build_frame(m_ch, m_rd, m_a, m_d, m_ph, m_l, m_r);
        m_ch = 1'b0;
        m_ph = 1'b0;
      end
      if (acc_c) begin
        m_ch = 1'b1; m_rd = cmd_read; m_a = cmd_addr; m_d = cmd_data;
      end
      if (acc_p) begin
        m_ph = 1'b1; m_l = pcm_left; m_r = pcm_right;
      end
      m_pos = np;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("sync", 32'(sync), 32'(m_pos >= 0 && m_pos < 16));
      check("frame_start", 32'(frame_start), 32'(m_pos == 0));
      check("sdata", 32'(sdata), 32'((m_pos >= 0) ? m_frame[255 - m_pos] : 1'b0));
      check("cmd_ready", 32'(cmd_ready), 32'(!m_ch));
      check("pcm_ready", 32'(pcm_ready), 32'(!m_ph));
    end
  end

  // Reassemble each transmitted frame from the serial line for the directed field checks.
  logic [255:0] cap = '0, last_frame = '0;
  int cap_sync = 0, last_sync = 0, frames_done = 0;
  int cyc = 0, last_fs = 0, fs_period = 0;

  always @(negedge clk) begin
    cyc++;
    if (m_ok && m_pos >= 0) begin
      if (m_pos == 0) begin
        cap = '0;
        cap_sync = 0;
      end
      cap[255 - m_pos] = sdata;
      cap_sync += int'(sync);
      if (m_pos == 255) begin
        last_frame = cap;
        last_sync = cap_sync;
        frames_done++;
      end
    end
    if (frame_start) begin
      fs_period = cyc - last_fs;
      last_fs = cyc;
    end
  end

  task automatic wait_pos(input int p);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (m_pos == p) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL wait_pos: bit %0d not reached", p);
  endtask

  task automatic applyStimulus(input bit rd, input logic [6:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic applyPcm(input logic [SW-1:0] l, input logic [SW-1:0] r);
    @(posedge clk); #1;
    pcm_valid = 1'b1; pcm_left = l; pcm_right = r;
    @(posedge clk); #1;
    pcm_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] f, input logic [31:0] t,
                             input logic [31:0] s1, input logic [31:0] s2,
                             input logic [31:0] s3, input logic [31:0] s4);
    check({name, "_tag"}, tag_of(f), t);
    check({name, "_slot1"}, slot_of(f, 1), s1);
    check({name, "_slot2"}, slot_of(f, 2), s2);
    check({name, "_slot3"}, slot_of(f, 3), s3);
    check({name, "_slot4"}, slot_of(f, 4), s4);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_data = '0;
    pcm_valid = 1'b0; pcm_left = '0; pcm_right = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_sync", 32'(sync), 32'd0);
    check("reset_sdata", 32'(sdata), 32'd0);
    check("reset_fs", 32'(frame_start), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_pcm_ready", 32'(pcm_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Idle frames
    wait_pos(255);
    wait_pos(255);
    check("idle_frame", 32'(|last_frame), 32'd0);
    check("idle_sync_bits", 32'(last_sync), 32'd16);
    wait_pos(0);
    check("fs_period", 32'(fs_period), 32'd256);

    // Register write
    wait_pos(128);
    applyStimulus(1'b0, 7'h0E, 16'h0808);
    wait_pos(255);
    check("write_ready_before_latch", 32'(cmd_ready), 32'd0);
    check("write_prev_tag", tag_of(last_frame), 32'h0);
    wait_pos(0);
    check("write_ready_after_latch", 32'(cmd_ready), 32'd1);
    wait_pos(255);
    checkOutput("write", last_frame, 32'hE000, 32'h0E000, 32'h08080, 32'h0, 32'h0);

    // Register read
    wait_pos(40);
    applyStimulus(1'b1, 7'h26, 16'hBEEF);
    wait_pos(255);
    wait_pos(255);
    checkOutput("read", last_frame, 32'hC000, 32'hA6000, 32'h0, 32'h0, 32'h0);

    // Stereo sample, then a frame without one
    wait_pos(10);
    applyPcm(18'h1FFFF, 18'h20000);
    wait_pos(255);
    wait_pos(255);
    checkOutput("pcm", last_frame, 32'h9800, 32'h0, 32'h0, 32'h7FFFC, 32'h80000);
    wait_pos(255);
    checkOutput("pcm_gone", last_frame, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Command accepted in the latch cycle goes out one frame later
    wait_pos(254);
    applyStimulus(1'b1, 7'h1A, 16'h0000);
    check("late_ready", 32'(cmd_ready), 32'd0);
    wait_pos(255);
    check("late_absent_tag", tag_of(last_frame), 32'h0);
    wait_pos(255);
    check("late_present_tag", tag_of(last_frame), 32'hC000);
    check("late_present_slot1", slot_of(last_frame, 1), 32'h9A000);

    // Reset mid-frame drops the pending command
    wait_pos(50);
    applyStimulus(1'b0, 7'h02, 16'h1234);
    wait_pos(99);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_sync", 32'(sync), 32'd0);
    check("midreset_sdata", 32'(sdata), 32'd0);
    check("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midreset_pcm_ready", 32'(pcm_ready), 32'd1);
    @(negedge clk);
    check("restart_fs", 32'(frame_start), 32'd1);
    check("restart_sync", 32'(sync), 32'd1);
    wait_pos(255);
    check("restart_frame_empty", 32'(|last_frame), 32'd0);

    // Randomized traffic with one reset pulse, checked by the model every cycle
    for (int c = 0; c < 256 * 20; c++) begin
      @(posedge clk); #1;
      cmd_valid = ($urandom_range(0, 39) == 0);
      cmd_read  = 1'($urandom);
      cmd_addr  = 7'($urandom);
      cmd_data  = 16'($urandom);
      pcm_valid = ($urandom_range(0, 29) == 0);
      pcm_left  = SW'($urandom);
      pcm_right = SW'($urandom);
      rst       = (c == 3000);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; pcm_valid = 1'b0; rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
